// File: rtl/rom_loader.sv
// rom_loader: fills a 32-bit byte-enabled ROM array from a host byte stream.
// Bytes are gathered little-endian into a one-word buffer. The buffer is
// written to the array when it is full, when the host moves to another word,
// or when the download ends. The CPU is held in reset until the image is
// loaded.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (running byte sum on SUM).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, CPU held, waiting for the first download
// S_LOAD  | accepting host bytes into the word buffer
// S_FLUSH | writing the buffered word to the array (WS+1 CE cycles)
// S_DONE  | image loaded, CPU released, waiting for a new download
module rom_loader #(
    parameter int AW = 4,
    parameter int WS = 0
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CE,
    input  logic          DL_EN,
    input  logic          DL_WR,
    input  logic [23:0]   DL_ADDR,
    input  logic [7:0]    DL_DATA,
    output logic          DL_WAIT,
    output logic          MEM_nCE,
    output logic          MEM_nWE,
    output logic [3:0]    MEM_nBE,
    output logic [AW-1:0] MEM_A,
    output logic [31:0]   MEM_DO,
    output logic          CPU_RESn,
    output logic          DONE,
    output logic          ERR,
    output logic [31:0]   SUM
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = (WS > 0) ? $clog2(WS + 1) : 1;
    localparam logic [CW-1:0] WS_CNT = CW'(WS);

    logic [1:0]    state;
    logic [31:0]   data;
    logic [3:0]    mask;
    logic [AW-1:0] wa;
    logic [CW-1:0] cnt;
    logic          dl_en_q;

    logic [1:0]    lane;
    logic [AW-1:0] byte_wa;
    logic          in_range;
    logic          word_change;
    logic          accept;
    logic          dl_rise;
    logic [31:0]   data_nxt;
    logic [3:0]    mask_nxt;
    logic [AW-1:0] wa_nxt;

    assign lane        = DL_ADDR[1:0];
    assign byte_wa     = DL_ADDR[AW+1:2];
    assign in_range    = (DL_ADDR >> (AW + 2)) == 24'd0;
    assign word_change = (state == S_LOAD) & DL_WR & (mask != 4'h0) & (byte_wa != wa);
    assign DL_WAIT     = (state == S_FLUSH) | word_change;
    assign accept      = CE & DL_WR & ~DL_WAIT & (state == S_LOAD);
    assign dl_rise     = DL_EN & ~dl_en_q;

    // Buffer contents after this cycle's byte; out-of-range bytes leave it untouched.
    always_comb begin
        data_nxt = data;
        mask_nxt = mask;
        wa_nxt   = wa;
        if (accept && in_range) begin
            data_nxt[{lane, 3'b000} +: 8] = DL_DATA;
            mask_nxt[lane]                = 1'b1;
            wa_nxt                        = byte_wa;
        end
    end

    // Sequencer, word buffer and registered array/CPU outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= S_IDLE;
            data     <= 32'd0;
            mask     <= 4'h0;
            wa       <= '0;
            cnt      <= '0;
            dl_en_q  <= 1'b0;
            MEM_nCE  <= 1'b1;
            MEM_nWE  <= 1'b1;
            MEM_nBE  <= 4'hF;
            MEM_A    <= '0;
            MEM_DO   <= 32'd0;
            CPU_RESn <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else if (CE) begin
            dl_en_q <= DL_EN;
            data    <= data_nxt;
            mask    <= mask_nxt;
            wa      <= wa_nxt;
            if (accept && !in_range)
                ERR <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (DL_EN)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    if (mask_nxt == 4'hF || word_change || (!DL_EN && mask_nxt != 4'h0)) begin
                        state   <= S_FLUSH;
                        cnt     <= WS_CNT;
                        MEM_nCE <= 1'b0;
                        MEM_nWE <= 1'b0;
                        MEM_nBE <= ~mask_nxt;
                        MEM_A   <= wa_nxt;
                        MEM_DO  <= data_nxt;
                    end else if (!DL_EN) begin
                        state    <= S_DONE;
                        CPU_RESn <= 1'b1;
                        DONE     <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cnt == '0) begin
                        mask    <= 4'h0;
                        MEM_nCE <= 1'b1;
                        MEM_nWE <= 1'b1;
                        MEM_nBE <= 4'hF;
                        if (DL_EN) begin
                            state <= S_LOAD;
                        end else begin
                            state    <= S_DONE;
                            CPU_RESn <= 1'b1;
                            DONE     <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (dl_rise) begin
                        state    <= S_LOAD;
                        CPU_RESn <= 1'b0;
                        DONE     <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    // Running sum of in-range bytes, restarted whenever a new download begins.
    always_ff @(posedge CLK) begin
        if (RES) begin
            sum <= 32'd0;
        end else if (CE) begin
            if ((state == S_IDLE && DL_EN) || (state == S_DONE && dl_rise))
                sum <= 32'd0;
            else if (accept && in_range)
                sum <= sum + {24'd0, DL_DATA};
        end
    end

    assign SUM = sum;
`else
    assign SUM = 32'd0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: a WS=0 instance checked through a write scoreboard
// and a WS=2 instance used for wait-state timing and mid-write reset.
module tb_rom_loader;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  nbe;
        logic        nwe;
        logic [31:0] stamp;
    } wr_t;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] dm;
        logic [3:0]  nbe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        ce = 1'b1, dl_en = 1'b0, dl_wr = 1'b0;
    logic [23:0] dl_addr = 24'd0;
    logic [7:0]  dl_data = 8'd0;
    logic        dl_wait0, nce0, nwe0, cpu_resn0, done0, err0;
    logic [3:0]  nbe0, a0;
    logic [31:0] do0, sum0;

    logic        ce2 = 1'b1, dl_en2 = 1'b0, dl_wr2 = 1'b0;
    logic [23:0] dl_addr2 = 24'd0;
    logic [7:0]  dl_data2 = 8'd0;
    logic        dl_wait2, nce2, nwe2, cpu_resn2, done2, err2;
    logic [3:0]  nbe2, a2;
    logic [31:0] do2, sum2;

    wr_t  obs_q[$];
    exp_t exp_q[$];

    rom_loader #(.AW(4), .WS(0)) dut0 (
        .CLK(clk), .RES(rst), .CE(ce), .DL_EN(dl_en), .DL_WR(dl_wr),
        .DL_ADDR(dl_addr), .DL_DATA(dl_data), .DL_WAIT(dl_wait0),
        .MEM_nCE(nce0), .MEM_nWE(nwe0), .MEM_nBE(nbe0), .MEM_A(a0), .MEM_DO(do0),
        .CPU_RESn(cpu_resn0), .DONE(done0), .ERR(err0), .SUM(sum0)
    );

    rom_loader #(.AW(4), .WS(2)) dut2 (
        .CLK(clk), .RES(rst), .CE(ce2), .DL_EN(dl_en2), .DL_WR(dl_wr2),
        .DL_ADDR(dl_addr2), .DL_DATA(dl_data2), .DL_WAIT(dl_wait2),
        .MEM_nCE(nce2), .MEM_nWE(nwe2), .MEM_nBE(nbe2), .MEM_A(a2), .MEM_DO(do2),
        .CPU_RESn(cpu_resn2), .DONE(done2), .ERR(err2), .SUM(sum2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle the WS=0 instance has its array selected.
    always @(negedge clk)
        if (!rst && nce0 === 1'b0)
            obs_q.push_back({a0, do0, nbe0, nwe0, 32'(cyc)});

    task automatic send_byte(input logic [23:0] a, input logic [7:0] d,
                             output bit waited, output int acc_cyc);
        bit acc;
        waited = 0; acc = 0;
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            if (dl_wait0) waited = 1; else acc = 1;
            @(posedge clk); #1;
        end
        acc_cyc = cyc;
        dl_wr = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h", a);
        end
    endtask

    task automatic send_byte2(input logic [23:0] a, input logic [7:0] d, output bit waited);
        bit acc;
        waited = 0; acc = 0;
        dl_addr2 = a; dl_data2 = d; dl_wr2 = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            if (dl_wait2) waited = 1; else acc = 1;
            @(posedge clk); #1;
        end
        dl_wr2 = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout2 addr=%h", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({nce0, nwe0, nbe0, a0, do0} !== {1'b1, 1'b1, 4'hF, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mem got %b %b %h %h %h", nce0, nwe0, nbe0, a0, do0);
        end
        checks++;
        if ({cpu_resn0, done0, err0, dl_wait0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got resn=%b done=%b err=%b wait=%b exp 0000",
                     cpu_resn0, done0, err0, dl_wait0);
        end
        checks++;
        if (sum0 !== 32'h0) begin
            errors++; $display("FAIL reset_sum got %h exp 0", sum0);
        end
    endtask

    task automatic test_full_word();
        bit w, any_w; int c; exp_t e; wr_t o;
        any_w = 0;
        dl_en = 1'b1; @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send_byte(24'(i), 8'(8'h11 * (i + 1)), w, c);
            any_w |= w;
        end
        exp_q.push_back('{4'd0, 32'h44332211, 32'hFFFFFFFF, 4'h0});
        @(negedge clk);
        checks++;
        if (dl_wait0 !== 1'b1 || nwe0 !== 1'b0) begin
            errors++; $display("FAIL full_flush_start wait=%b nwe=%b exp 1 0", dl_wait0, nwe0);
        end
        checks++;
        if (any_w) begin
            errors++; $display("FAIL full_stream_wait got 1 exp 0");
        end
        repeat (3) @(posedge clk); #1;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].stamp !== 32'(c)) begin
                errors++; $display("FAIL full_latency got cyc %0d exp %0d", obs_q[0].stamp, c);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL full_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if ({o.a, o.d & e.dm, o.nbe, o.nwe} !== {e.a, e.d & e.dm, e.nbe, 1'b0}) begin
                errors++;
                $display("FAIL full_wr got a=%h d=%h nbe=%b nwe=%b exp a=%h d=%h nbe=%b",
                         o.a, o.d, o.nbe, o.nwe, e.a, e.d, e.nbe);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_word_change();
        bit w; int c; exp_t e; wr_t o;
        send_byte(24'd5, 8'hAA, w, c);
        send_byte(24'd8, 8'hBB, w, c);
        exp_q.push_back('{4'd1, 32'h0000AA00, 32'h0000FF00, 4'b1101});
        checks++;
        if (w !== 1'b1) begin
            errors++; $display("FAIL word_change_wait got %b exp 1", w);
        end
        send_byte(24'd8, 8'hCC, w, c);
        checks++;
        if (w !== 1'b0) begin
            errors++; $display("FAIL lane_overwrite_wait got %b exp 0", w);
        end
        dl_en = 1'b0;
        exp_q.push_back('{4'd2, 32'h000000CC, 32'h000000FF, 4'b1110});
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({done0, cpu_resn0} !== 2'b11) begin
            errors++; $display("FAIL change_done got done=%b resn=%b exp 1 1", done0, cpu_resn0);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL change_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if ({o.a, o.d & e.dm, o.nbe, o.nwe} !== {e.a, e.d & e.dm, e.nbe, 1'b0}) begin
                errors++;
                $display("FAIL change_wr got a=%h d=%h nbe=%b nwe=%b exp a=%h d=%h nbe=%b",
                         o.a, o.d, o.nbe, o.nwe, e.a, e.d, e.nbe);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_dl_en_fall();
        bit w; int c; exp_t e; wr_t o;
        @(posedge clk); #1; dl_en = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({done0, cpu_resn0} !== 2'b00) begin
            errors++; $display("FAIL restart got done=%b resn=%b exp 0 0", done0, cpu_resn0);
        end
        send_byte(24'd2, 8'h5A, w, c);
        dl_en = 1'b0;
        exp_q.push_back('{4'd0, 32'h005A0000, 32'h00FF0000, 4'b1011});
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({done0, cpu_resn0} !== 2'b11) begin
            errors++; $display("FAIL fall_done got done=%b resn=%b exp 1 1", done0, cpu_resn0);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL fall_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if ({o.a, o.d & e.dm, o.nbe, o.nwe} !== {e.a, e.d & e.dm, e.nbe, 1'b0}) begin
                errors++;
                $display("FAIL fall_wr got a=%h d=%h nbe=%b nwe=%b exp a=%h d=%h nbe=%b",
                         o.a, o.d, o.nbe, o.nwe, e.a, e.d, e.nbe);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_err();
        bit w; int c; exp_t e; wr_t o;
        @(posedge clk); #1; dl_en = 1'b1;
        @(posedge clk); #1;
        send_byte(24'h40, 8'h99, w, c);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err0 !== 1'b1) begin
            errors++; $display("FAIL err_set got %b exp 1", err0);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL err_no_write got %0d writes exp 0", obs_q.size());
        end
        send_byte(24'd4, 8'h77, w, c);
        dl_en = 1'b0;
        exp_q.push_back('{4'd1, 32'h00000077, 32'h000000FF, 4'b1110});
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({done0, err0} !== 2'b11) begin
            errors++; $display("FAIL err_done got done=%b err=%b exp 1 1", done0, err0);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL err_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if ({o.a, o.d & e.dm, o.nbe, o.nwe} !== {e.a, e.d & e.dm, e.nbe, 1'b0}) begin
                errors++;
                $display("FAIL err_wr got a=%h d=%h nbe=%b nwe=%b exp a=%h d=%h nbe=%b",
                         o.a, o.d, o.nbe, o.nwe, e.a, e.d, e.nbe);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_checksum();
        bit w; int c; exp_t e; wr_t o; logic [31:0] exp_sum;
`ifdef ROM_LOADER_CHECKSUM_EN
        exp_sum = 32'h3FC;
`else
        exp_sum = 32'h0;
`endif
        @(posedge clk); #1; dl_en = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({cpu_resn0, err0} !== 2'b01) begin
            errors++; $display("FAIL second_dl got resn=%b err=%b exp 0 1", cpu_resn0, err0);
        end
        for (int i = 0; i < 4; i++) send_byte(24'(i), 8'hFF, w, c);
        exp_q.push_back('{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sum0 !== exp_sum) begin
            errors++; $display("FAIL checksum got %h exp %h", sum0, exp_sum);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL sum_wr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if ({o.a, o.d & e.dm, o.nbe, o.nwe} !== {e.a, e.d & e.dm, e.nbe, 1'b0}) begin
                errors++;
                $display("FAIL sum_wr got a=%h d=%h nbe=%b nwe=%b exp a=%h d=%h nbe=%b",
                         o.a, o.d, o.nbe, o.nwe, e.a, e.d, e.nbe);
            end
        end
        exp_q.delete(); obs_q.delete();
        dl_en = 1'b0;
    endtask

    task automatic test_wait_states();
        bit w, any_w; int low, bad_wait; logic [3:0] fa, fnbe; logic [31:0] fd;
        dl_en2 = 1'b1; ce2 = 1'b1;
        @(posedge clk); #1;
        any_w = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte2(24'(i), 8'(i + 1), w);
            any_w |= w;
        end
        low = 0; bad_wait = 0; fa = 4'hx; fd = 32'hx; fnbe = 4'hx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (nwe2 === 1'b0) begin
                if (low == 0) begin fa = a2; fd = do2; fnbe = nbe2; end
                low++;
                if (dl_wait2 !== 1'b1) bad_wait++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (low !== 3) begin
            errors++; $display("FAIL ws2_low got %0d exp 3", low);
        end
        checks++;
        if (bad_wait !== 0 || any_w) begin
            errors++; $display("FAIL ws2_wait got bad=%0d stream_wait=%b exp 0 0", bad_wait, any_w);
        end
        checks++;
        if ({fa, fd, fnbe} !== {4'd0, 32'h04030201, 4'h0}) begin
            errors++; $display("FAIL ws2_wr got a=%h d=%h nbe=%b exp 0 04030201 0000", fa, fd, fnbe);
        end
        for (int i = 4; i < 8; i++) send_byte2(24'(i), 8'(i + 1), w);
        low = 0; bad_wait = 0;
        for (int i = 0; i < 12; i++) begin
            ce2 = ~ce2;
            @(negedge clk);
            if (nwe2 === 1'b0) begin
                low++;
                if (dl_wait2 !== 1'b1) bad_wait++;
            end
            @(posedge clk); #1;
        end
        ce2 = 1'b1;
        checks++;
        if (low !== 6 || bad_wait !== 0) begin
            errors++; $display("FAIL ws2_ce_toggle got low=%0d bad_wait=%0d exp 6 0", low, bad_wait);
        end
    endtask

    task automatic test_reset_mid_flush();
        bit w;
        for (int i = 8; i < 12; i++) send_byte2(24'(i), 8'hC0, w);
        @(negedge clk);
        checks++;
        if (nwe2 !== 1'b0) begin
            errors++; $display("FAIL midflush_start got nwe=%b exp 0", nwe2);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({nce2, nwe2, nbe2, a2, cpu_resn2} !== {1'b1, 1'b1, 4'hF, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL midflush_reset got nce=%b nwe=%b nbe=%b a=%h resn=%b exp 1 1 1111 0 0",
                     nce2, nwe2, nbe2, a2, cpu_resn2);
        end
        rst = 1'b0; dl_en2 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_full_word();
        test_word_change();
        test_dl_en_fall();
        test_err();
        test_checksum();
        test_wait_states();
        test_reset_mid_flush();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
